scan_subject_feeder: RTL and testbench
======================================

SCAN_SUBJECT_FEEDER -- requirements
Module: scan_subject_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the subject-word buffer depth in 128-bit words (power of two, 2..16).
REQ-002 Parameter ADDR_QUERY, default 32'h40, SHALL be the query register address.
REQ-003 Parameter ADDR_SUBJ, default 32'h50, SHALL be the subject-word push address.
REQ-004 Parameter ADDR_STAT, default 32'h60, SHALL be the status/clear address.
REQ-005 PicoClk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 PicoRst  in  1  SHALL be the reset, asynchronous and active-high.
REQ-007 PicoAddr  in  32  SHALL be the bus address, valid with PicoRd/PicoWr.
REQ-008 PicoDataIn  in  128  SHALL be the write data.
REQ-009 PicoRd  in  1  SHALL be the read strobe.
REQ-010 PicoWr  in  1  SHALL be the write strobe.
REQ-011 PicoDataOut  out  128  SHALL be the registered read data.
REQ-012 res_valid  out  1  SHALL flag a valid residue toward the downstream comparator.
REQ-013 res_ready  in  1  SHALL be downstream acceptance; transfer occurs when res_valid && res_ready.
REQ-014 res_data  out  5  SHALL be the current subject residue.
REQ-015 res_query  out  5  SHALL be the query residue paired with res_data.
REQ-016 res_last  out  1  SHALL mark the final residue of a subject.
REQ-017 res_index  out  16  SHALL be the residue position within the current subject.

Function
REQ-018 Write to ADDR_QUERY SHALL store PicoDataIn[4:0] in the query register on the next edge.
REQ-019 Write to ADDR_SUBJ SHALL push PicoDataIn into the FIFO; residue k (0..24) occupies bits [5k+4:5k], k=0 emitted first; bit 127 is the last-word flag; bits [126:125] are ignored.
REQ-020 A push when FIFO is full SHALL be accepted only if a pop occurs in the same cycle; otherwise it SHALL be dropped and the sticky overflow flag set.
REQ-021 The unpacker SHALL have two states: IDLE (no word loaded) and EMIT (word loaded, res_valid=1).
REQ-022 In IDLE with FIFO non-empty, the unpacker SHALL pop one word, latch it with the current query register value and last flag, set residue counter to 0, and enter EMIT; res_valid rises the following cycle.
REQ-023 Latency: subject write at cycle N SHALL yield res_valid=1 at cycle N+2 when the FIFO was empty and the unpacker idle.
REQ-024 In EMIT, res_data SHALL be residue[counter]; res_query SHALL be the query latched at pop; a later query write SHALL NOT affect the word in flight.
REQ-025 While res_valid && !res_ready, res_data, res_query, res_last, and res_index SHALL hold stable.
REQ-026 On transfer with counter<24, the counter SHALL advance by 1.
REQ-027 On transfer with counter=24 and FIFO non-empty, the next word SHALL be popped in that cycle and EMIT continued with no bubble; with FIFO empty, the unpacker SHALL enter IDLE and res_valid SHALL be 0 next cycle.
REQ-028 res_last SHALL be 1 only when counter=24 and the latched last flag is 1.
REQ-029 res_index SHALL increment on each transfer, return to 0 after a transfer with res_last=1, and wrap 65535->0.
REQ-030 A 16-bit emitted counter SHALL increment on each transfer, wrapping at 65535.
REQ-031 Reads SHALL be registered, returning data one cycle after PicoRd as follows.
  - ADDR_QUERY: {123'b0, query}.
  - ADDR_STAT: bits [15:0] emitted count, [20:16] FIFO occupancy, [21] overflow, [22] unpacker in EMIT, remaining bits 0.
  - Any other address, or no read: 128'h0.
REQ-032 Write to ADDR_STAT SHALL clear the overflow flag and emitted counter, data ignored; a transfer in the same cycle SHALL leave the counter at 0.

Reset
REQ-033 PicoRst=1 SHALL immediately force the following: FIFO empty, unpacker IDLE, query=0, overflow=0, emitted count=0, res_index=0, res_valid=0, res_data=0, res_query=0, res_last=0, PicoDataOut=0.
REQ-034 Reset asserted mid-EMIT SHALL discard the in-flight word and all buffered words; no transfer SHALL occur after release until a new push.

Verification
REQ-035 Write query 5'h0B, then one subject word with residues k=k mod 32 and bit127=1, res_ready=1 -> 25 transfers on consecutive cycles: res_data 0..24, res_query 0B, res_index 0..24, res_last only on the 25th, then res_valid=0.
REQ-036 Two words pushed back-to-back, res_ready=1 -> 50 transfers with no bubble between residue 24 and the next word's residue 0.
REQ-037 Hold res_ready=0 for 10 cycles at residue 7 -> outputs are stable for all 10 cycles, and resume with residue 7.
REQ-038 With res_ready=0, push FIFO_DEPTH+2 words -> the unpacker holds one word, the FIFO fills, one push is dropped, STAT bit 21=1; a write to ADDR_STAT clears the flag.
REQ-039 Query write mid-word -> the remaining residues keep the old query; the next word carries the new query.
REQ-040 Assert PicoRst during EMIT with 2 words buffered -> res_valid falls asynchronously, STAT reads all-zero after release, and no residues are emitted.

Source files
------------

// File: rtl/scan_subject_feeder.sv
// Subject-residue feeder: bus-loaded query and 128-bit subject words,
// unpacked into a stream of 5-bit residues for a downstream comparator.
module scan_subject_feeder #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] ADDR_QUERY = 32'h40,
  parameter logic [31:0] ADDR_SUBJ  = 32'h50,
  parameter logic [31:0] ADDR_STAT  = 32'h60
) (
  input  logic         PicoClk,
  input  logic         PicoRst,
  input  logic [31:0]  PicoAddr,
  input  logic [127:0] PicoDataIn,
  input  logic         PicoRd,
  input  logic         PicoWr,
  output logic [127:0] PicoDataOut,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [4:0]   res_data,
  output logic [4:0]   res_query,
  output logic         res_last,
  output logic [15:0]  res_index
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  // FIFO storage: {last flag, 25 residues}
  logic [125:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic [4:0]    r_query;
  logic [124:0]  r_word;
  logic          r_wlast;
  logic [4:0]    r_wquery;
  logic [4:0]    r_cnt;
  logic [15:0]   r_idx;
  logic [15:0]   r_emit;
  logic          r_ovf;
  logic [127:0]  r_rdata;

  logic          w_wr_query;
  logic          w_wr_subj;
  logic          w_wr_stat;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_xfer;
  logic          w_end;
  logic [6:0]    w_pos;
  logic [125:0]  w_rd;
  logic [127:0]  w_rdata;
  logic          w_unused;

  assign w_wr_query = PicoWr && (PicoAddr == ADDR_QUERY);
  assign w_wr_subj  = PicoWr && (PicoAddr == ADDR_SUBJ);
  assign w_wr_stat  = PicoWr && (PicoAddr == ADDR_STAT);

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  // A full FIFO still takes a push when the unpacker frees a slot.
  assign w_push  = w_wr_subj && (!w_full || w_pop);
  assign w_rd    = r_mem[r_rptr];

  assign res_valid = (r_state == S_EMIT);
  assign w_xfer    = res_valid && res_ready;
  assign w_end     = (r_cnt == 5'd24);
  assign w_pos     = 7'(r_cnt) * 7'd5;
  assign res_data  = r_word[w_pos +: 5];
  assign res_query = r_wquery;
  assign res_last  = res_valid && w_end && r_wlast;
  assign res_index = r_idx;

  assign PicoDataOut = r_rdata;
  assign w_unused    = ^PicoDataIn[126:125];

  // Unpacker state register
  always_ff @(posedge PicoClk or posedge PicoRst) begin
    if (PicoRst) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  // Unpacker next state and pop decision
  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_state_nx = S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_xfer && w_end) begin
          if (!w_empty) w_pop = 1'b1;
          else          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // FIFO word storage, no reset needed behind the pointers
  always_ff @(posedge PicoClk) begin
    if (w_push) r_mem[r_wptr] <= {PicoDataIn[127], PicoDataIn[124:0]};
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge PicoClk or posedge PicoRst) begin
    if (PicoRst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_wr_stat)                   r_ovf <= 1'b0;
      else if (w_wr_subj && !w_push)   r_ovf <= 1'b1;
    end
  end

  // Query register
  always_ff @(posedge PicoClk or posedge PicoRst) begin
    if (PicoRst)         r_query <= '0;
    else if (w_wr_query) r_query <= PicoDataIn[4:0];
  end

  // In-flight word, its query snapshot and residue counter
  always_ff @(posedge PicoClk or posedge PicoRst) begin
    if (PicoRst) begin
      r_word   <= '0;
      r_wlast  <= 1'b0;
      r_wquery <= '0;
      r_cnt    <= '0;
    end else if (w_pop) begin
      r_word   <= w_rd[124:0];
      r_wlast  <= w_rd[125];
      r_wquery <= r_query;
      r_cnt    <= '0;
    end else if (w_xfer && !w_end) begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Position within subject, restarts after the final residue
  always_ff @(posedge PicoClk or posedge PicoRst) begin
    if (PicoRst)     r_idx <= '0;
    else if (w_xfer) r_idx <= res_last ? 16'd0 : r_idx + 16'd1;
  end

  // Emitted-residue counter; a status write wins over a transfer
  always_ff @(posedge PicoClk or posedge PicoRst) begin
    if (PicoRst)        r_emit <= '0;
    else if (w_wr_stat) r_emit <= '0;
    else if (w_xfer)    r_emit <= r_emit + 16'd1;
  end

  // Read data mux
  always_comb begin
    w_rdata = '0;
    if (PicoRd) begin
      unique case (1'b1)
        (PicoAddr == ADDR_QUERY): w_rdata = {123'b0, r_query};
        (PicoAddr == ADDR_STAT):  w_rdata = {105'b0, res_valid, r_ovf,
                                             5'(r_count), r_emit};
        default:                  w_rdata = '0;
      endcase
    end
  end

  // Registered read port
  always_ff @(posedge PicoClk or posedge PicoRst) begin
    if (PicoRst) r_rdata <= '0;
    else         r_rdata <= w_rdata;
  end

endmodule

// File: tb/tb_scan_subject_feeder.sv
// Scoreboard bench for scan_subject_feeder: directed subject words,
// expected residues queued at push time, checked by a negedge monitor.
module tb_scan_subject_feeder;

  localparam logic [31:0] AQ = 32'h40;
  localparam logic [31:0] AS = 32'h50;
  localparam logic [31:0] AT = 32'h60;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  addr = '0;
  logic [127:0] din = '0;
  logic         rd = 1'b0;
  logic         wr = 1'b0;
  logic [127:0] dout;
  logic         rv;
  logic         rr = 1'b0;
  logic [4:0]   rdat;
  logic [4:0]   rq;
  logic         rl;
  logic [15:0]  ridx;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [4:0]  d;
    logic [4:0]  q;
    logic        l;
    logic [15:0] i;
  } exp_t;

  exp_t sb[$];
  logic [15:0] exp_idx = '0;

  scan_subject_feeder dut (
    .PicoClk(clk), .PicoRst(rst), .PicoAddr(addr),
    .PicoDataIn(din), .PicoRd(rd), .PicoWr(wr),
    .PicoDataOut(dout), .res_valid(rv), .res_ready(rr),
    .res_data(rdat), .res_query(rq), .res_last(rl),
    .res_index(ridx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic wrb(input logic [31:0] a, input logic [127:0] d);
    addr = a; din = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic rdb(input logic [31:0] a, output logic [127:0] d);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    d = dout;
  endtask

  function automatic logic [127:0] mkw(input int base, input int step,
                                       input bit last, input bit junk);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < 25; k++) w[5*k +: 5] = 5'((base + step*k) % 32);
    w[126:125] = junk ? 2'b11 : 2'b00;
    w[127] = last;
    return w;
  endfunction

  task automatic expect_word(input logic [127:0] w, input logic [4:0] q);
    exp_t e;
    for (int k = 0; k < 25; k++) begin
      e.d = w[5*k +: 5];
      e.q = q;
      e.l = w[127] && (k == 24);
      e.i = exp_idx;
      sb.push_back(e);
      exp_idx = e.l ? 16'd0 : exp_idx + 16'd1;
    end
  endtask

  // Monitor: every transfer must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rv && rr) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL xfer: unexpected residue d=%0h idx=%0d", rdat, ridx);
      end else begin
        e = sb.pop_front();
        if ({rdat, rq, rl, ridx} !== e) begin
          n_fail++;
          $display("FAIL xfer: got d=%0h q=%0h l=%0b i=%0d want d=%0h q=%0h l=%0b i=%0d",
                   rdat, rq, rl, ridx, e.d, e.q, e.l, e.i);
        end
      end
    end
  end

  initial begin
    logic [127:0] w, r;
    logic [127:0] wa, wb;

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", 128'(rv), 128'd0);
    check("rst_out", {rdat, rq, rl, ridx}, '0);
    check("rst_dout", dout, '0);
    rdb(AT, r);
    check("rst_stat", r, '0);

    // single word, query 0B, full-rate drain
    rr = 1'b1;
    wrb(AQ, 128'h0B);
    rdb(AQ, r);
    check("query_rd", r, 128'h0B);
    w = mkw(0, 1, 1'b1, 1'b1);
    expect_word(w, 5'h0B);
    wrb(AS, w);
    check("lat_n1", 128'(rv), 128'd0);
    tick();
    check("lat_n2", 128'(rv), 128'd1);
    repeat (25) tick();
    check("one_done", 128'(rv), 128'd0);

    // two words back to back, no bubble at word boundary
    wa = mkw(31, 31, 1'b0, 1'b0);
    wb = mkw(5, 3, 1'b1, 1'b0);
    expect_word(wa, 5'h0B);
    expect_word(wb, 5'h0B);
    wrb(AS, wa);
    wrb(AS, wb);
    repeat (50) tick();
    check("two_done", 128'(rv), 128'd0);

    // backpressure at residue 7
    rr = 1'b0;
    w = mkw(3, 2, 1'b1, 1'b0);
    expect_word(w, 5'h0B);
    wrb(AS, w);
    tick();
    rr = 1'b1;
    repeat (7) tick();
    rr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("stall_hold", {rv, rdat, rq, ridx},
            {1'b1, 5'd17, 5'h0B, 16'd7});
      tick();
    end
    rr = 1'b1;
    repeat (18) tick();
    check("stall_done", 128'(rv), 128'd0);

    // overflow: one word in unpacker, FIFO full, last push dropped
    rr = 1'b0;
    for (int n = 0; n < 6; n++) begin
      w = mkw(n, 1, 1'b1, 1'b0);
      if (n < 5) expect_word(w, 5'h0B);
      wrb(AS, w);
    end
    rdb(AT, r);
    check("ovf_stat", r, 128'h640064);
    wrb(AT, 128'hFFFF);
    rdb(AT, r);
    check("ovf_clr", r, 128'h440000);
    rr = 1'b1;
    repeat (125) tick();
    check("ovf_drain", 128'(rv), 128'd0);
    rdb(AT, r);
    check("cnt_stat", r, 128'h7D);

    // query change mid-word affects only the next word
    rr = 1'b0;
    wrb(AQ, 128'h03);
    wa = mkw(7, 5, 1'b1, 1'b0);
    wb = mkw(2, 7, 1'b1, 1'b1);
    expect_word(wa, 5'h03);
    expect_word(wb, 5'h1C);
    wrb(AS, wa);
    wrb(AS, wb);
    rr = 1'b1;
    repeat (10) tick();
    wrb(AQ, 128'h1C);
    repeat (39) tick();
    check("q_done", 128'(rv), 128'd0);

    // reset mid-EMIT with two words buffered
    rr = 1'b0;
    for (int n = 0; n < 3; n++) wrb(AS, mkw(n, 1, 1'b1, 1'b0));
    check("pre_rst_valid", 128'(rv), 128'd1);
    rst = 1'b1;
    #1;
    check("async_valid", 128'(rv), 128'd0);
    check("async_out", {rdat, rq, rl, ridx}, '0);
    tick();
    rst = 1'b0;
    exp_idx = '0;
    rr = 1'b1;
    rdb(AT, r);
    check("post_rst_stat", r, '0);
    rdb(AQ, r);
    check("post_rst_query", r, '0);
    repeat (30) tick();
    check("post_rst_idle", 128'(rv), 128'd0);

    check("sb_empty", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
